// File: rtl/frame_checker_pkg.sv
// frame_checker_pkg: constants and types shared between the frame generator and the
// frame checker (header layout, test magic, statistics width, frame summary record).
package frame_checker_pkg;

    // Test frame header layout (byte offsets within the frame, fields big-endian)
    localparam logic [31:0] TEST_MAGIC     = 32'h5441_4E4C;
    localparam int unsigned MAGIC_OFFSET   = 14;
    localparam int unsigned SEQ_OFFSET     = 18;
    localparam int unsigned PAYLOAD_OFFSET = 22;

    localparam int unsigned STAT_WIDTH       = 64;
    localparam int unsigned SEQ_WIDTH        = 32;
    localparam int unsigned BYTE_CNT_WIDTH   = 16;
    // Summary id field is sized for the largest supported ID_WIDTH (8)
    localparam int unsigned SUMMARY_ID_WIDTH = 8;

    typedef struct packed {
        logic [SUMMARY_ID_WIDTH-1:0] id;
        logic                        is_test;
        logic                        bad;
        logic [SEQ_WIDTH-1:0]        seq;
        logic [BYTE_CNT_WIDTH-1:0]   bytes;
    } frame_summary_t;

    typedef enum logic [0:0] {
        StIdle,
        StRunning
    } state_e;

endpackage

// File: rtl/frame_checker_parser.sv
// frame_checker_parser: always-ready AXI-Stream sink front end. Tracks frame boundaries,
// extracts the test header on the first beat, accumulates byte count and error flags, and
// emits one registered frame_summary_t per counted frame.
// Optional: FRAME_CHECKER_PAYLOAD_CHECK_EN adds a per-byte payload offset check.
module frame_checker_parser
    import frame_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ID_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    count_en,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   axis_s_data,
    input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
    input  logic                    axis_s_last,
    input  logic [DATA_WIDTH/8-1:0] axis_s_user,
    input  logic [ID_WIDTH-1:0]     axis_s_id,
    input  logic                    axis_s_valid,
    output logic                    axis_s_ready,
    output frame_summary_t          summary,
    output logic                    summary_valid
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = $clog2(KEEP_WIDTH + 1);

    logic                        accept;
    logic                        first;
    logic [31:0]                 hdr_magic;
    logic [SEQ_WIDTH-1:0]        hdr_seq;
    logic                        hdr_is_test;
    logic [CNT_WIDTH-1:0]        beat_cnt;
    logic [BYTE_CNT_WIDTH-1:0]   base;
    logic                        beat_pay_err;

    logic [SUMMARY_ID_WIDTH-1:0] cur_id;
    logic                        cur_is_test;
    logic [SEQ_WIDTH-1:0]        cur_seq;
    logic                        cur_bad;
    logic                        cur_counted;
    logic [BYTE_CNT_WIDTH-1:0]   cur_bytes;

    logic                        in_frame_q;
    logic [SUMMARY_ID_WIDTH-1:0] id_q;
    logic                        is_test_q;
    logic [SEQ_WIDTH-1:0]        seq_q;
    logic                        bad_q;
    logic                        counted_q;
    logic [BYTE_CNT_WIDTH-1:0]   byte_acc_q;

    // Never backpressures; only held low while reset is asserted
    assign axis_s_ready = ~rst;
    assign accept       = axis_s_valid & axis_s_ready;
    assign first        = accept & ~in_frame_q;

    // Header fields as they would appear on a first beat
    always_comb begin
        hdr_magic = {axis_s_data[MAGIC_OFFSET*8 +: 8], axis_s_data[(MAGIC_OFFSET+1)*8 +: 8],
                     axis_s_data[(MAGIC_OFFSET+2)*8 +: 8], axis_s_data[(MAGIC_OFFSET+3)*8 +: 8]};
        hdr_seq   = {axis_s_data[SEQ_OFFSET*8 +: 8], axis_s_data[(SEQ_OFFSET+1)*8 +: 8],
                     axis_s_data[(SEQ_OFFSET+2)*8 +: 8], axis_s_data[(SEQ_OFFSET+3)*8 +: 8]};
        hdr_is_test = (hdr_magic == TEST_MAGIC) && axis_s_keep[MAGIC_OFFSET+3]
                      && axis_s_keep[SEQ_OFFSET+3];
    end

    // Popcount of keep for the current beat
    always_comb begin
        beat_cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            beat_cnt = beat_cnt + CNT_WIDTH'(axis_s_keep[i]);
        end
    end

    // Frame offset of byte 0 of the current beat
    assign base = first ? '0 : byte_acc_q;

`ifdef FRAME_CHECKER_PAYLOAD_CHECK_EN
    // Every valid payload byte must carry its own frame offset modulo 256
    always_comb begin
        logic [BYTE_CNT_WIDTH-1:0] off;
        beat_pay_err = 1'b0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            off = base + BYTE_CNT_WIDTH'(i);
            if (axis_s_keep[i] && (off >= BYTE_CNT_WIDTH'(PAYLOAD_OFFSET))
                && (axis_s_data[i*8 +: 8] != off[7:0])) begin
                beat_pay_err = 1'b1;
            end
        end
    end
`else
    logic unused_data;
    assign unused_data  = ^axis_s_data;
    assign beat_pay_err = 1'b0;
`endif

    // Merge this beat into the running frame context
    always_comb begin
        cur_id      = first ? SUMMARY_ID_WIDTH'(axis_s_id) : id_q;
        cur_is_test = first ? hdr_is_test : is_test_q;
        cur_seq     = first ? hdr_seq : seq_q;
        // A start while the frame is open disqualifies it from counting
        cur_counted = (first ? count_en : counted_q) & ~clear;
        cur_bad     = (first ? 1'b0 : bad_q) | (|axis_s_user) | (beat_pay_err & cur_is_test);
        cur_bytes   = base + BYTE_CNT_WIDTH'(beat_cnt);
    end

    // Frame context and stage-1 summary register
    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame_q    <= 1'b0;
            id_q          <= '0;
            is_test_q     <= 1'b0;
            seq_q         <= '0;
            bad_q         <= 1'b0;
            counted_q     <= 1'b0;
            byte_acc_q    <= '0;
            summary       <= '0;
            summary_valid <= 1'b0;
        end else begin
            summary_valid <= accept & axis_s_last & cur_counted;
            if (accept) begin
                in_frame_q <= ~axis_s_last;
                id_q       <= cur_id;
                is_test_q  <= cur_is_test;
                seq_q      <= cur_seq;
                bad_q      <= cur_bad;
                counted_q  <= cur_counted;
                byte_acc_q <= cur_bytes;
                if (axis_s_last) begin
                    summary <= '{id: cur_id, is_test: cur_is_test, bad: cur_bad,
                                 seq: cur_seq, bytes: cur_bytes};
                end
            end else if (clear) begin
                counted_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/frame_checker.sv
// frame_checker: receive-side frame checker. Run/idle FSM, per-ID statistics counters with
// sequence tracking, and a registered statistics read port.
// Optional: FRAME_CHECKER_PAYLOAD_CHECK_EN enables payload checking in the parser.
module frame_checker
    import frame_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ID_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    output logic                    running,
    input  logic [DATA_WIDTH-1:0]   axis_s_data,
    input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
    input  logic                    axis_s_last,
    input  logic [DATA_WIDTH/8-1:0] axis_s_user,
    input  logic [ID_WIDTH-1:0]     axis_s_id,
    input  logic                    axis_s_valid,
    output logic                    axis_s_ready,
    input  logic [ID_WIDTH-1:0]     stat_id,
    output logic [STAT_WIDTH-1:0]   stat_frames,
    output logic [STAT_WIDTH-1:0]   stat_bytes,
    output logic [STAT_WIDTH-1:0]   stat_bad,
    output logic [STAT_WIDTH-1:0]   stat_seq_err,
    output logic [STAT_WIDTH-1:0]   stat_other
);

    localparam int unsigned NUM_IDS = 2 ** ID_WIDTH;

    state_e               state_q, state_d;
    logic                 clear;
    logic                 count_en;
    frame_summary_t       summary;
    logic                 summary_valid;
    logic [ID_WIDTH-1:0]  sid;
    logic                 unused_summary_id;

    logic [STAT_WIDTH-1:0] frames_q  [NUM_IDS];
    logic [STAT_WIDTH-1:0] bytes_q   [NUM_IDS];
    logic [STAT_WIDTH-1:0] bad_q     [NUM_IDS];
    logic [STAT_WIDTH-1:0] seq_err_q [NUM_IDS];
    logic [SEQ_WIDTH-1:0]  expected_q[NUM_IDS];
    logic [NUM_IDS-1:0]    seq_valid_q;
    logic [STAT_WIDTH-1:0] other_q;

    logic inc_other, inc_bad, inc_good, inc_seq_err;

    // Run/idle control; stop dominates start, and any honoured start clears statistics
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        if (stop) begin
            state_d = StIdle;
        end else if (start) begin
            state_d = StRunning;
            clear   = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign running  = (state_q == StRunning);
    assign count_en = running & ~clear;

    frame_checker_parser #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_parser (
        .clk           (clk),
        .rst           (rst),
        .count_en      (count_en),
        .clear         (clear),
        .axis_s_data   (axis_s_data),
        .axis_s_keep   (axis_s_keep),
        .axis_s_last   (axis_s_last),
        .axis_s_user   (axis_s_user),
        .axis_s_id     (axis_s_id),
        .axis_s_valid  (axis_s_valid),
        .axis_s_ready  (axis_s_ready),
        .summary       (summary),
        .summary_valid (summary_valid)
    );

    assign sid               = summary.id[ID_WIDTH-1:0];
    assign unused_summary_id = ^summary.id;

    // Stage 2 decision: which counters the registered summary bumps
    always_comb begin
        inc_other   = 1'b0;
        inc_bad     = 1'b0;
        inc_good    = 1'b0;
        inc_seq_err = 1'b0;
        if (summary_valid) begin
            if (!summary.is_test) begin
                inc_other = 1'b1;
            end else if (summary.bad) begin
                inc_bad = 1'b1;
            end else begin
                inc_good    = 1'b1;
                inc_seq_err = seq_valid_q[sid] && (summary.seq != expected_q[sid]);
            end
        end
    end

    // Stage 2 read-modify-write; the arrays are read and written in the same cycle, so a
    // following frame on the same ID always sees this result. A clear overrides any update.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                frames_q[i]   <= '0;
                bytes_q[i]    <= '0;
                bad_q[i]      <= '0;
                seq_err_q[i]  <= '0;
                expected_q[i] <= '0;
            end
            seq_valid_q <= '0;
            other_q     <= '0;
        end else begin
            if (inc_other) begin
                other_q <= other_q + 1'b1;
            end
            if (inc_bad) begin
                bad_q[sid] <= bad_q[sid] + 1'b1;
            end
            if (inc_good) begin
                frames_q[sid]    <= frames_q[sid] + 1'b1;
                bytes_q[sid]     <= bytes_q[sid] + STAT_WIDTH'(summary.bytes);
                // In order or resync, the next expected value is always seq+1
                expected_q[sid]  <= summary.seq + 1'b1;
                seq_valid_q[sid] <= 1'b1;
            end
            if (inc_seq_err) begin
                seq_err_q[sid] <= seq_err_q[sid] + 1'b1;
            end
        end
    end

    // Registered statistics read port
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames  <= '0;
            stat_bytes   <= '0;
            stat_bad     <= '0;
            stat_seq_err <= '0;
            stat_other   <= '0;
        end else begin
            stat_frames  <= frames_q[stat_id];
            stat_bytes   <= bytes_q[stat_id];
            stat_bad     <= bad_q[stat_id];
            stat_seq_err <= seq_err_q[stat_id];
            stat_other   <= other_q;
        end
    end

endmodule

// File: tb/tb_frame_checker.sv
// tb_frame_checker: table-driven directed bench for frame_checker, plus hand-written
// sequences for stop/start timing, back-to-back frames and mid-frame reset.
module tb_frame_checker;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst, start, stop;
    logic            running;
    logic [DW-1:0]   axis_s_data;
    logic [KW-1:0]   axis_s_keep, axis_s_user;
    logic            axis_s_last, axis_s_valid, axis_s_ready;
    logic [IW-1:0]   axis_s_id, stat_id;
    logic [63:0]     stat_frames, stat_bytes, stat_bad, stat_seq_err, stat_other;

    int n_vec = 0;
    int n_err = 0;

    frame_checker #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .running      (running),
        .axis_s_data  (axis_s_data),
        .axis_s_keep  (axis_s_keep),
        .axis_s_last  (axis_s_last),
        .axis_s_user  (axis_s_user),
        .axis_s_id    (axis_s_id),
        .axis_s_valid (axis_s_valid),
        .axis_s_ready (axis_s_ready),
        .stat_id      (stat_id),
        .stat_frames  (stat_frames),
        .stat_bytes   (stat_bytes),
        .stat_bad     (stat_bad),
        .stat_seq_err (stat_seq_err),
        .stat_other   (stat_other)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [2:0]  id;
        logic [31:0] seq;
        int          nbytes;
        logic        user_err;
        logic        is_magic;
        logic [63:0] e_frames;
        logic [63:0] e_bytes;
        logic [63:0] e_bad;
        logic [63:0] e_seq_err;
        logic [63:0] e_other;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d", name, act, act, exp);
        end
    endtask

    function automatic logic [KW-1:0] mk_keep(input int n);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < KW; i++) k[i] = (i < n);
        return k;
    endfunction

    // Payload bytes carry their frame offset; first beat gets a header
    function automatic logic [DW-1:0] mk_data(input logic [31:0] seq, input logic magic,
                                              input int base);
        logic [DW-1:0] d;
        logic [31:0]   m;
        m = magic ? 32'h5441_4E4C : 32'h1234_5678;
        for (int i = 0; i < KW; i++) d[i*8 +: 8] = 8'(base + i);
        if (base == 0) begin
            for (int i = 0; i < 14; i++) d[i*8 +: 8] = 8'hA0 + 8'(i);
            for (int i = 0; i < 4; i++) begin
                d[(14+i)*8 +: 8] = m[(3-i)*8 +: 8];
                d[(18+i)*8 +: 8] = seq[(3-i)*8 +: 8];
            end
        end
        return d;
    endfunction

    task automatic drive(input logic [2:0] id, input logic [DW-1:0] data, input int nbytes,
                         input logic last, input logic uerr);
        @(negedge clk);
        axis_s_valid = 1'b1;
        axis_s_id    = id;
        axis_s_data  = data;
        axis_s_keep  = mk_keep(nbytes);
        axis_s_last  = last;
        axis_s_user  = '0;
        if (uerr) axis_s_user[nbytes-1] = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        axis_s_valid = 1'b0;
        axis_s_last  = 1'b0;
        axis_s_user  = '0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_id(input string tag, input logic [2:0] id, input logic [63:0] ef,
                            input logic [63:0] eb, input logic [63:0] ebad,
                            input logic [63:0] ese, input logic [63:0] eoth);
        @(negedge clk);
        stat_id = id;
        @(negedge clk);
        check({tag, ".frames"}, stat_frames, ef);
        check({tag, ".bytes"}, stat_bytes, eb);
        check({tag, ".bad"}, stat_bad, ebad);
        check({tag, ".seq_err"}, stat_seq_err, ese);
        check({tag, ".other"}, stat_other, eoth);
    endtask

    initial begin
        logic [DW-1:0] d;

        //           start id    seq           nb  uerr magic frames bytes bad se other
        vecs[0]  = '{1'b1, 3'd2, 32'd5,        64, 1'b0, 1'b1, 64'd1, 64'd64,  64'd0, 64'd0, 64'd0};
        vecs[1]  = '{1'b0, 3'd2, 32'd6,        64, 1'b0, 1'b1, 64'd2, 64'd128, 64'd0, 64'd0, 64'd0};
        vecs[2]  = '{1'b0, 3'd2, 32'd7,        64, 1'b0, 1'b1, 64'd3, 64'd192, 64'd0, 64'd0, 64'd0};
        vecs[3]  = '{1'b1, 3'd1, 32'd10,       64, 1'b0, 1'b1, 64'd1, 64'd64,  64'd0, 64'd0, 64'd0};
        vecs[4]  = '{1'b0, 3'd1, 32'd11,       30, 1'b0, 1'b1, 64'd2, 64'd94,  64'd0, 64'd0, 64'd0};
        vecs[5]  = '{1'b0, 3'd1, 32'd13,       30, 1'b0, 1'b1, 64'd3, 64'd124, 64'd0, 64'd1, 64'd0};
        vecs[6]  = '{1'b0, 3'd1, 32'd14,       30, 1'b0, 1'b1, 64'd4, 64'd154, 64'd0, 64'd1, 64'd0};
        vecs[7]  = '{1'b0, 3'd3, 32'hFFFFFFFF, 64, 1'b0, 1'b1, 64'd1, 64'd64,  64'd0, 64'd0, 64'd0};
        vecs[8]  = '{1'b0, 3'd3, 32'd0,        64, 1'b0, 1'b1, 64'd2, 64'd128, 64'd0, 64'd0, 64'd0};
        vecs[9]  = '{1'b0, 3'd3, 32'd5,        64, 1'b1, 1'b1, 64'd2, 64'd128, 64'd1, 64'd0, 64'd0};
        vecs[10] = '{1'b0, 3'd3, 32'd9,        64, 1'b0, 1'b0, 64'd2, 64'd128, 64'd1, 64'd0, 64'd1};
        vecs[11] = '{1'b0, 3'd2, 32'd100,      22, 1'b0, 1'b1, 64'd1, 64'd22,  64'd0, 64'd0, 64'd1};
        vecs[12] = '{1'b0, 3'd3, 32'd1,        40, 1'b0, 1'b1, 64'd3, 64'd168, 64'd1, 64'd0, 64'd1};
        vecs[13] = '{1'b0, 3'd4, 32'd0,        21, 1'b0, 1'b1, 64'd0, 64'd0,   64'd0, 64'd0, 64'd2};

        rst = 1'b1; start = 1'b0; stop = 1'b0; stat_id = '0;
        axis_s_valid = 1'b0; axis_s_last = 1'b0; axis_s_data = '0;
        axis_s_keep = '0; axis_s_user = '0; axis_s_id = '0;

        // Reset state
        wait_cycles(3);
        check("ready_in_rst", {63'd0, axis_s_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {63'd0, axis_s_ready}, 64'd1);
        wait_cycles(2);
        check("running_after_rst", {63'd0, running}, 64'd0);
        check("frames_after_rst", stat_frames, 64'd0);
        check("other_after_rst", stat_other, 64'd0);

        // Table of single-beat frames
        for (int r = 0; r < 14; r++) begin
            if (vecs[r].start) pulse_start();
            drive(vecs[r].id, mk_data(vecs[r].seq, vecs[r].is_magic, 0), vecs[r].nbytes,
                  1'b1, vecs[r].user_err);
            idle();
            wait_cycles(2);
            check_id($sformatf("vec%0d", r), vecs[r].id, vecs[r].e_frames, vecs[r].e_bytes,
                     vecs[r].e_bad, vecs[r].e_seq_err, vecs[r].e_other);
        end
        check("running_in_run", {63'd0, running}, 64'd1);

        // Corrupted payload byte 30
        d = mk_data(32'd0, 1'b1, 0);
        d[30*8 +: 8] = 8'h00;
        drive(3'd5, d, 64, 1'b1, 1'b0);
        idle();
        wait_cycles(2);
`ifdef FRAME_CHECKER_PAYLOAD_CHECK_EN
        check_id("payload", 3'd5, 64'd0, 64'd0, 64'd1, 64'd0, 64'd2);
`else
        check_id("payload", 3'd5, 64'd1, 64'd64, 64'd0, 64'd0, 64'd2);
`endif

        // Two-beat 100 B frame spanning a stop pulse is still counted
        drive(3'd6, mk_data(32'd9, 1'b1, 0), 64, 1'b0, 1'b0);
        @(negedge clk);
        axis_s_valid = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("running_after_stop", {63'd0, running}, 64'd1 - 64'd1);
        drive(3'd6, mk_data(32'd0, 1'b0, 64), 36, 1'b1, 1'b0);
        idle();
        wait_cycles(2);
        check_id("stopspan", 3'd6, 64'd1, 64'd100, 64'd0, 64'd0, 64'd2);
        drive(3'd6, mk_data(32'd10, 1'b1, 0), 64, 1'b1, 1'b0);
        idle();
        wait_cycles(2);
        check_id("afterstop", 3'd6, 64'd1, 64'd100, 64'd0, 64'd0, 64'd2);

        // Back-to-back single-beat frames on id 0, seq 0..7
        @(negedge clk);
        stat_id = 3'd0;
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            drive(3'd0, mk_data(32'(k), 1'b1, 0), 64, 1'b1, 1'b0);
        end
        idle();
        @(negedge clk);
        check("b2b_latency.frames", stat_frames, 64'd7);
        @(negedge clk);
        check("b2b.frames", stat_frames, 64'd8);
        check("b2b.bytes", stat_bytes, 64'd512);
        check("b2b.seq_err", stat_seq_err, 64'd0);
        check("b2b.other", stat_other, 64'd0);

        // start and stop together: stop wins, nothing cleared
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop.running", {63'd0, running}, 64'd0);
        @(negedge clk);
        check("startstop.frames", stat_frames, 64'd8);

        // Frame open at start is ignored entirely
        pulse_start();
        drive(3'd7, mk_data(32'd1, 1'b1, 0), 64, 1'b0, 1'b0);
        idle();
        pulse_start();
        drive(3'd7, mk_data(32'd0, 1'b0, 64), 10, 1'b1, 1'b0);
        idle();
        wait_cycles(2);
        check_id("openatstart", 3'd7, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

        // Mid-frame reset drops the partial frame; next beat is a first beat
        drive(3'd7, mk_data(32'd2, 1'b1, 0), 64, 1'b0, 1'b0);
        @(negedge clk);
        axis_s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("ready_mid_rst", {63'd0, axis_s_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("running_mid_rst", {63'd0, running}, 64'd0);
        pulse_start();
        drive(3'd7, mk_data(32'd3, 1'b1, 0), 40, 1'b1, 1'b0);
        idle();
        wait_cycles(2);
        check_id("after_rst", 3'd7, 64'd1, 64'd40, 64'd0, 64'd0, 64'd0);
        check_id("after_rst_id0", 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
